// File: rtl/axi_resp_pkg.sv
// Shared types for the AXI write-response generator: FSM states, response codes,
// and the queued entry (transaction ID plus error tag).
package axi_resp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } resp_fsm_t;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   // Widest ID any instance may carry; narrower IDs are zero-extended into it.
   localparam int ID_MAX_W = 16;

   typedef struct packed {
      logic [ID_MAX_W-1:0] id;
      logic                err;
   } axi_entry_t;

   function automatic logic [1:0] resp_code(input logic err);
      return err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_id_fifo.sv
// Synchronous in-order FIFO holding accepted AW entries until their B response
// completes. Pointers wrap modulo DEPTH (power of two).
module axi_id_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/axi_b_resp_gen.sv
// AXI write-response generator: queues AW IDs and returns B responses in order
// after a programmable idle delay. Optional tracing under AXI_B_RESP_TRACE_EN.
module axi_b_resp_gen
   import axi_resp_pkg::*;
#(
   parameter int ID_WIDTH    = 4,
   parameter int DEPTH       = 4,
   parameter int DELAY_WIDTH = 4
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
`ifdef AXI_B_RESP_TRACE_EN
   input  int                       file_fd,
`endif
   input  logic                     aw_valid,
   output logic                     aw_ready,
   input  logic [ID_WIDTH-1:0]      aw_id,
   output logic                     b_valid,
   input  logic                     b_ready,
   output logic [ID_WIDTH-1:0]      b_id,
   output logic [1:0]               b_resp,
   input  logic [DELAY_WIDTH-1:0]   cfg_delay,
   input  logic                     cfg_err,
   output logic [$clog2(DEPTH):0]   outstanding,
   output logic                     busy
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   resp_fsm_t              state;
   logic [DELAY_WIDTH-1:0] delay_cnt;
   axi_entry_t             push_entry;
   axi_entry_t             head_entry;
   resp_fsm_t              launch_state;
   logic                   push;
   logic                   pop;
   logic                   full;
   logic                   empty;
   logic                   more_after_pop;

   assign push_entry     = '{id: ID_MAX_W'(aw_id), err: cfg_err};
   assign aw_ready       = !full;
   assign push           = aw_valid && aw_ready;
   assign b_valid        = (state == RESP);
   assign pop            = b_valid && b_ready;
   assign busy           = !empty;
   assign b_id           = b_valid ? ID_WIDTH'(head_entry.id) : '0;
   assign b_resp         = b_valid ? resp_code(head_entry.err) : AXI_RESP_OKAY;
   assign launch_state   = (cfg_delay != '0) ? WAIT : RESP;
   // Head is still in the queue while RESP is active, so more than one entry
   // (or a same-cycle push) means another response follows this pop.
   assign more_after_pop = (outstanding > CNT_W'(1)) || push;

   axi_id_fifo #(
      .WIDTH ($bits(axi_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .push  (push),
      .din   (push_entry),
      .pop   (pop),
      .dout  (head_entry),
      .full  (full),
      .empty (empty),
      .count (outstanding)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         delay_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!empty) begin
                  state     <= launch_state;
                  delay_cnt <= cfg_delay;
               end
            end
            WAIT: begin
               delay_cnt <= delay_cnt - DELAY_WIDTH'(1);
               if (delay_cnt == DELAY_WIDTH'(1)) state <= RESP;
            end
            RESP: begin
               if (b_ready) begin
                  if (more_after_pop) begin
                     state     <= launch_state;
                     delay_cnt <= cfg_delay;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef AXI_B_RESP_TRACE_EN
   always @(posedge sys_clk) begin
      if (sys_rst_n) begin
         if (push) $display("aw id=%0d", aw_id);
         if (pop)  $display("b id=%0d resp=%0d @%0t", b_id, b_resp, $time);
      end
   end
`endif

endmodule
